// File: rtl/mipi_rx_pkg.sv
// -----------------------------------------------------------------------------
// mipi_rx_pkg
// Shared definitions for the MIPI CSI-2 receive packet controller:
//   - CSI-2 short-packet data type codes (frame/line start/end)
//   - upper bound of the short-packet data type range
//   - controller state encoding
// -----------------------------------------------------------------------------
package mipi_rx_pkg;

    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] DT_LS        = 6'h02;
    localparam logic [5:0] DT_LE        = 6'h03;
    localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PAYLOAD  = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

endpackage

// File: rtl/mipi_rx_ecc.sv
// -----------------------------------------------------------------------------
// mipi_rx_ecc
// Combinational CSI-2 packet-header ECC generator (6 parity bits over the
// 24-bit header {WC MSB, WC LSB, DI}).
// Ports:
//   data_i [23:0]  header bytes 0..2, byte0 in [7:0]
//   ecc_o  [5:0]   computed ECC, to be compared against header byte3[5:0]
// -----------------------------------------------------------------------------
module mipi_rx_ecc (
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);

    // Each parity bit is the XOR of the header bits selected by its mask.
    localparam logic [23:0] P0_MASK = 24'hF12CB7;
    localparam logic [23:0] P1_MASK = 24'hF2555B;
    localparam logic [23:0] P2_MASK = 24'h749A6D;
    localparam logic [23:0] P3_MASK = 24'hB8E38E;
    localparam logic [23:0] P4_MASK = 24'hDF03F0;
    localparam logic [23:0] P5_MASK = 24'hEFFC00;

    assign ecc_o[0] = ^(data_i & P0_MASK);
    assign ecc_o[1] = ^(data_i & P1_MASK);
    assign ecc_o[2] = ^(data_i & P2_MASK);
    assign ecc_o[3] = ^(data_i & P3_MASK);
    assign ecc_o[4] = ^(data_i & P4_MASK);
    assign ecc_o[5] = ^(data_i & P5_MASK);

endmodule

// File: rtl/mipi_rx_packet_ctrl.sv
// -----------------------------------------------------------------------------
// mipi_rx_packet_ctrl
// CSI-2 receive packet controller. Takes aligned 4-lane words, decodes the
// packet header, emits short-packet strobes, streams long-packet payload with
// byte enables, and discards CRC/trailer.
// Optional feature: define MIPI_RX_PACKET_ECC_CHECK_EN to check the header ECC
// (byte3[5:0]); otherwise byte3 is ignored and no ECC logic is built.
// Ports:
//   clk_i, reset_i (async, active high)
//   lane_valid_i, lane_byte_i[31:0]       aligned input words, [7:0] first
//   frame_start_o/frame_end_o/line_start_o/line_end_o   1-cycle strobes
//   vc_o[1:0], data_type_o[5:0], word_count_o[15:0]      latched header
//   payload_valid_o, payload_o[31:0], payload_be_o[3:0], payload_last_o
//   pkt_error_o   1-cycle error strobe
//   busy_o        state != IDLE
// -----------------------------------------------------------------------------
module mipi_rx_packet_ctrl
    import mipi_rx_pkg::*;
#(
    parameter logic [15:0] WC_LIMIT = 16'd8192
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        lane_valid_i,
    input  logic [31:0] lane_byte_i,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        line_start_o,
    output logic        line_end_o,
    output logic [1:0]  vc_o,
    output logic [5:0]  data_type_o,
    output logic [15:0] word_count_o,
    output logic        payload_valid_o,
    output logic [31:0] payload_o,
    output logic [3:0]  payload_be_o,
    output logic        payload_last_o,
    output logic        pkt_error_o,
    output logic        busy_o
);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_remaining;
    // Cleared by reset; set once lane_valid_i has been seen low so a word
    // stream that was already in flight across reset is not taken as header.
    logic        r_armed;

    logic        r_fs, r_fe, r_ls, r_le;
    logic [1:0]  r_vc;
    logic [5:0]  r_dt;
    logic [15:0] r_wc;
    logic        r_pl_valid;
    logic [31:0] r_pl_data;
    logic [3:0]  r_pl_be;
    logic        r_pl_last;
    logic        r_err;

    logic [1:0]  w_hdr_vc;
    logic [5:0]  w_hdr_dt;
    logic [15:0] w_hdr_wc;
    logic        w_hdr_take;
    logic        w_is_short;
    logic        w_ecc_ok;
    logic [3:0]  w_be;
    logic        w_last_word;

    assign w_hdr_dt    = lane_byte_i[5:0];
    assign w_hdr_vc    = lane_byte_i[7:6];
    assign w_hdr_wc    = lane_byte_i[23:8];
    assign w_hdr_take  = (r_state == ST_IDLE) && lane_valid_i && r_armed;
    assign w_is_short  = (w_hdr_dt <= DT_SHORT_MAX);
    assign w_last_word = (r_remaining <= 16'd4);

`ifdef MIPI_RX_PACKET_ECC_CHECK_EN
    logic [5:0] w_ecc;
    logic [1:0] w_unused_ecc_msb;

    mipi_rx_ecc u_ecc (
        .data_i (lane_byte_i[23:0]),
        .ecc_o  (w_ecc)
    );

    assign w_ecc_ok         = (w_ecc == lane_byte_i[29:24]);
    assign w_unused_ecc_msb = lane_byte_i[31:30];
`else
    logic [7:0] w_unused_byte3;

    assign w_ecc_ok       = 1'b1;
    assign w_unused_byte3 = lane_byte_i[31:24];
`endif

    always_comb begin
        w_be = 4'b1111;
        case (r_remaining)
            16'd1:   w_be = 4'b0001;
            16'd2:   w_be = 4'b0011;
            16'd3:   w_be = 4'b0111;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Short packets always pass through WAIT_END: it exits on the first low
    // cycle, which also enforces the low gap required before the next header.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_take) begin
                    if (!w_ecc_ok || w_is_short || (w_hdr_wc == 16'd0) ||
                        (w_hdr_wc > WC_LIMIT)) begin
                        w_next_state = ST_WAIT_END;
                    end else begin
                        w_next_state = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!lane_valid_i) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_word) begin
                    w_next_state = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (!lane_valid_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_armed     <= 1'b0;
            r_remaining <= '0;
            r_fs        <= 1'b0;
            r_fe        <= 1'b0;
            r_ls        <= 1'b0;
            r_le        <= 1'b0;
            r_vc        <= '0;
            r_dt        <= '0;
            r_wc        <= '0;
            r_pl_valid  <= 1'b0;
            r_pl_data   <= '0;
            r_pl_be     <= '0;
            r_pl_last   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_fs       <= 1'b0;
            r_fe       <= 1'b0;
            r_ls       <= 1'b0;
            r_le       <= 1'b0;
            r_pl_valid <= 1'b0;
            r_pl_data  <= '0;
            r_pl_be    <= '0;
            r_pl_last  <= 1'b0;
            r_err      <= 1'b0;

            if (!lane_valid_i) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_hdr_take) begin
                        if (!w_ecc_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_vc <= w_hdr_vc;
                            r_dt <= w_hdr_dt;
                            r_wc <= w_hdr_wc;
                            if (w_is_short) begin
                                case (w_hdr_dt)
                                    DT_FS:   r_fs <= 1'b1;
                                    DT_FE:   r_fe <= 1'b1;
                                    DT_LS:   r_ls <= 1'b1;
                                    DT_LE:   r_le <= 1'b1;
                                    default: ;
                                endcase
                            end else if (w_hdr_wc > WC_LIMIT) begin
                                r_err <= 1'b1;
                            end else begin
                                r_remaining <= w_hdr_wc;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (lane_valid_i) begin
                        r_pl_valid  <= 1'b1;
                        r_pl_data   <= lane_byte_i;
                        r_pl_be     <= w_be;
                        r_pl_last   <= w_last_word;
                        r_remaining <= w_last_word ? 16'd0 : (r_remaining - 16'd4);
                    end else begin
                        r_err       <= 1'b1;
                        r_remaining <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_start_o   = r_fs;
    assign frame_end_o     = r_fe;
    assign line_start_o    = r_ls;
    assign line_end_o      = r_le;
    assign vc_o            = r_vc;
    assign data_type_o     = r_dt;
    assign word_count_o    = r_wc;
    assign payload_valid_o = r_pl_valid;
    assign payload_o       = r_pl_data;
    assign payload_be_o    = r_pl_be;
    assign payload_last_o  = r_pl_last;
    assign pkt_error_o     = r_err;
    assign busy_o          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mipi_rx_packet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mipi_rx_packet_ctrl
// Self-checking bench for mipi_rx_packet_ctrl. Expected payload beats are
// queued when stimulus is driven and popped by a monitor on the falling edge.
// Define MIPI_RX_PACKET_ECC_CHECK_EN to also exercise the header ECC check.
// -----------------------------------------------------------------------------
module tb_mipi_rx_packet_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        lane_valid_i;
    logic [31:0] lane_byte_i;
    logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
    logic [1:0]  vc_o;
    logic [5:0]  data_type_o;
    logic [15:0] word_count_o;
    logic        payload_valid_o;
    logic [31:0] payload_o;
    logic [3:0]  payload_be_o;
    logic        payload_last_o;
    logic        pkt_error_o;
    logic        busy_o;

    mipi_rx_packet_ctrl #(.WC_LIMIT(16'd8192)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .lane_valid_i    (lane_valid_i),
        .lane_byte_i     (lane_byte_i),
        .frame_start_o   (frame_start_o),
        .frame_end_o     (frame_end_o),
        .line_start_o    (line_start_o),
        .line_end_o      (line_end_o),
        .vc_o            (vc_o),
        .data_type_o     (data_type_o),
        .word_count_o    (word_count_o),
        .payload_valid_o (payload_valid_o),
        .payload_o       (payload_o),
        .payload_be_o    (payload_be_o),
        .payload_last_o  (payload_last_o),
        .pkt_error_o     (pkt_error_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_exp;

    int checks   = 0;
    int failures = 0;
    int n_fs = 0, n_fe = 0, n_ls = 0, n_le = 0;
    int n_err = 0, n_beat = 0, n_last = 0;

    // Reference CSI-2 header ECC, written out bit by bit.
    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                        input logic [15:0] wc);
        logic [23:0] p;
        p = {wc, vc, dt};
        return {2'b00, ref_ecc(p), p};
    endfunction

    // Monitor: counts strobes, checks payload beats against the scoreboard
    // and checks idle payload outputs are zero.
    always @(negedge clk_i) begin
        if (frame_start_o)  n_fs++;
        if (frame_end_o)    n_fe++;
        if (line_start_o)   n_ls++;
        if (line_end_o)     n_le++;
        if (pkt_error_o)    n_err++;
        if (payload_valid_o) begin
            n_beat++;
            if (payload_last_o) n_last++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected got data=%h be=%b last=%b expected none",
                         payload_o, payload_be_o, payload_last_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({payload_o, payload_be_o, payload_last_o} !== mon_exp) begin
                    failures++;
                    $display("FAIL beat got data=%h be=%b last=%b expected data=%h be=%b last=%b",
                             payload_o, payload_be_o, payload_last_o,
                             mon_exp.data, mon_exp.be, mon_exp.last);
                end
            end
        end else begin
            checks++;
            if (payload_o !== 32'd0 || payload_be_o !== 4'd0 || payload_last_o !== 1'b0) begin
                failures++;
                $display("FAIL idle_payload got data=%h be=%b last=%b expected zeros",
                         payload_o, payload_be_o, payload_last_o);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic v, input logic [31:0] d);
        @(posedge clk_i);
        #1;
        lane_valid_i = v;
        lane_byte_i  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'd0);
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] be, input logic last);
        beat_t b;
        b.data = d;
        b.be   = be;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic test_reset;
        reset_i      = 1'b1;
        lane_valid_i = 1'b0;
        lane_byte_i  = 32'd0;
        #2;
        checks++;
        if ({frame_start_o, frame_end_o, line_start_o, line_end_o, vc_o, data_type_o,
             word_count_o, payload_valid_o, payload_o, payload_be_o, payload_last_o,
             pkt_error_o, busy_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got nonzero outputs expected all zero");
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        idle(2);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b expected=0", busy_o);
        end
    endtask

    task automatic test_short_fs;
        int fs0 = n_fs, err0 = n_err;
        step(1'b1, hdr(2'd0, 6'h00, 16'h0000));
        step(1'b0, 32'd0);
        checks++;
        if (frame_start_o !== 1'b1) begin
            failures++;
            $display("FAIL fs_pulse got=%b expected=1", frame_start_o);
        end
        checks++;
        if ({vc_o, data_type_o, word_count_o} !== 24'd0) begin
            failures++;
            $display("FAIL fs_fields got vc=%h dt=%h wc=%h expected 0", vc_o, data_type_o, word_count_o);
        end
        idle(1);
        checks++;
        if (frame_start_o !== 1'b0) begin
            failures++;
            $display("FAIL fs_one_cycle got=%b expected=0", frame_start_o);
        end
        idle(2);
        @(negedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b0 || n_fs - fs0 != 1 || n_err != err0) begin
            failures++;
            $display("FAIL fs_summary got busy=%b fs=%0d err=%0d expected busy=0 fs=1 err=0",
                     busy_o, n_fs - fs0, n_err - err0);
        end
    endtask

    task automatic test_long_payload;
        int b0 = n_beat, l0 = n_last, e0 = n_err;
        push(32'h44332211, 4'b1111, 1'b0);
        push(32'h88776655, 4'b1111, 1'b0);
        push(32'h5A5AAA99, 4'b0011, 1'b1);
        step(1'b1, hdr(2'd1, 6'h2A, 16'd10));
        step(1'b1, 32'h44332211);
        checks++;
        if (vc_o !== 2'd1 || data_type_o !== 6'h2A || word_count_o !== 16'd10 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL long_fields got vc=%h dt=%h wc=%0d busy=%b expected vc=1 dt=2a wc=10 busy=1",
                     vc_o, data_type_o, word_count_o, busy_o);
        end
        step(1'b1, 32'h88776655);
        step(1'b1, 32'h5A5AAA99);
        step(1'b1, 32'hC0C0C0C0);
        step(1'b0, 32'd0);
        idle(3);
        @(negedge clk_i); #1;
        checks++;
        if (n_beat - b0 != 3 || n_last - l0 != 1 || n_err != e0 || exp_q.size() != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL long_summary got beats=%0d last=%0d err=%0d pending=%0d busy=%b expected 3 1 0 0 0",
                     n_beat - b0, n_last - l0, n_err - e0, exp_q.size(), busy_o);
        end
    endtask

    task automatic test_drop;
        int b0 = n_beat, l0 = n_last, e0 = n_err;
        push(32'hCAFEF00D, 4'b1111, 1'b0);
        step(1'b1, hdr(2'd0, 6'h2B, 16'd8));
        step(1'b1, 32'hCAFEF00D);
        step(1'b0, 32'd0);
        step(1'b0, 32'd0);
        checks++;
        if (pkt_error_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_error got err=%b busy=%b expected err=1 busy=0", pkt_error_o, busy_o);
        end
        idle(2);
        @(negedge clk_i); #1;
        checks++;
        if (n_beat - b0 != 1 || n_last != l0 || n_err - e0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drop_summary got beats=%0d last=%0d err=%0d expected 1 0 1",
                     n_beat - b0, n_last - l0, n_err - e0);
        end
    endtask

    task automatic test_wc_over;
        int b0 = n_beat, e0 = n_err;
        step(1'b1, hdr(2'd2, 6'h2A, 16'd9000));
        step(1'b1, 32'h11111111);
        checks++;
        if (pkt_error_o !== 1'b1 || busy_o !== 1'b1 || word_count_o !== 16'd9000) begin
            failures++;
            $display("FAIL wcover_error got err=%b busy=%b wc=%0d expected err=1 busy=1 wc=9000",
                     pkt_error_o, busy_o, word_count_o);
        end
        step(1'b1, 32'h22222222);
        checks++;
        if (pkt_error_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL wcover_wait got err=%b busy=%b expected err=0 busy=1", pkt_error_o, busy_o);
        end
        step(1'b0, 32'd0);
        step(1'b0, 32'd0);
        @(negedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b0 || n_beat != b0 || n_err - e0 != 1) begin
            failures++;
            $display("FAIL wcover_summary got busy=%b beats=%0d err=%0d expected 0 0 1",
                     busy_o, n_beat - b0, n_err - e0);
        end
    endtask

    task automatic test_back_to_back;
        int b0 = n_beat, l0 = n_last, e0 = n_err;
        int fs0 = n_fs, fe0 = n_fe, ls0 = n_ls, le0 = n_le;
        // WC=4: single full beat that is also last
        push(32'h01020304, 4'b1111, 1'b1);
        step(1'b1, hdr(2'd3, 6'h24, 16'd4));
        step(1'b1, 32'h01020304);
        step(1'b1, 32'hFFFF0000);
        step(1'b0, 32'd0);
        // WC=5: full beat then one-byte last beat
        push(32'hA1A2A3A4, 4'b1111, 1'b0);
        push(32'hB1B2B3B4, 4'b0001, 1'b1);
        step(1'b1, hdr(2'd0, 6'h2B, 16'd5));
        step(1'b1, 32'hA1A2A3A4);
        step(1'b1, 32'hB1B2B3B4);
        step(1'b1, 32'h0BADC0DE);
        step(1'b0, 32'd0);
        // WC=0 long packet: no payload
        step(1'b1, hdr(2'd0, 6'h2C, 16'd0));
        step(1'b1, 32'h33333333);
        step(1'b0, 32'd0);
        // LE held high straight into an FS-looking word: must be ignored
        step(1'b1, hdr(2'd0, 6'h03, 16'd0));
        step(1'b1, hdr(2'd0, 6'h00, 16'd0));
        checks++;
        if (line_end_o !== 1'b1 || data_type_o !== 6'h03) begin
            failures++;
            $display("FAIL b2b_le got le=%b dt=%h expected le=1 dt=03", line_end_o, data_type_o);
        end
        step(1'b1, hdr(2'd0, 6'h00, 16'd0));
        step(1'b0, 32'd0);
        step(1'b1, hdr(2'd0, 6'h01, 16'd0));
        step(1'b0, 32'd0);
        step(1'b1, hdr(2'd0, 6'h02, 16'd0));
        step(1'b0, 32'd0);
        // reserved short type: no strobe
        step(1'b1, hdr(2'd0, 6'h05, 16'h1234));
        step(1'b0, 32'd0);
        idle(3);
        @(negedge clk_i); #1;
        checks++;
        if (n_beat - b0 != 3 || n_last - l0 != 2 || n_err != e0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_payload got beats=%0d last=%0d err=%0d pending=%0d expected 3 2 0 0",
                     n_beat - b0, n_last - l0, n_err - e0, exp_q.size());
        end
        checks++;
        if (n_fs != fs0 || n_fe - fe0 != 1 || n_ls - ls0 != 1 || n_le - le0 != 1) begin
            failures++;
            $display("FAIL b2b_strobes got fs=%0d fe=%0d ls=%0d le=%0d expected 0 1 1 1",
                     n_fs - fs0, n_fe - fe0, n_ls - ls0, n_le - le0);
        end
        checks++;
        if (data_type_o !== 6'h05 || word_count_o !== 16'h1234 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_latch got dt=%h wc=%h busy=%b expected dt=05 wc=1234 busy=0",
                     data_type_o, word_count_o, busy_o);
        end
    endtask

    task automatic test_reset_mid;
        int l0 = n_last, e0 = n_err, fs0 = n_fs;
        int busy_seen = 0, fs_seen = 0;
        push(32'h77777777, 4'b1111, 1'b0);
        step(1'b1, hdr(2'd1, 6'h2A, 16'd16));
        step(1'b1, 32'h77777777);
        step(1'b1, 32'h88888888);
        @(negedge clk_i); #1;
        reset_i = 1'b1;
        #1;
        checks++;
        if ({frame_start_o, frame_end_o, line_start_o, line_end_o, vc_o, data_type_o,
             word_count_o, payload_valid_o, payload_o, payload_be_o, payload_last_o,
             pkt_error_o, busy_o} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got nonzero outputs expected all zero");
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, hdr(2'd0, 6'h00, 16'd0));
            if (busy_o !== 1'b0) busy_seen++;
            if (frame_start_o !== 1'b0) fs_seen++;
        end
        checks++;
        if (busy_seen != 0 || fs_seen != 0) begin
            failures++;
            $display("FAIL midreset_held got busy_cycles=%0d fs_cycles=%0d expected 0 0", busy_seen, fs_seen);
        end
        step(1'b0, 32'd0);
        step(1'b1, hdr(2'd0, 6'h00, 16'd0));
        step(1'b0, 32'd0);
        checks++;
        if (frame_start_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_rearm got fs=%b expected=1", frame_start_o);
        end
        idle(2);
        @(negedge clk_i); #1;
        checks++;
        if (n_last != l0 || n_err != e0 || n_fs - fs0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_summary got last=%0d err=%0d fs=%0d pending=%0d expected 0 0 1 0",
                     n_last - l0, n_err - e0, n_fs - fs0, exp_q.size());
        end
    endtask

`ifdef MIPI_RX_PACKET_ECC_CHECK_EN
    task automatic test_ecc;
        int fs0 = n_fs, e0 = n_err;
        logic [1:0]  vc_before = vc_o;
        logic [5:0]  dt_before = data_type_o;
        logic [15:0] wc_before = word_count_o;
        step(1'b1, hdr(2'd2, 6'h00, 16'h00A5) ^ 32'h0100_0000);
        step(1'b0, 32'd0);
        checks++;
        if (pkt_error_o !== 1'b1 || frame_start_o !== 1'b0) begin
            failures++;
            $display("FAIL ecc_bad got err=%b fs=%b expected err=1 fs=0", pkt_error_o, frame_start_o);
        end
        checks++;
        if (vc_o !== vc_before || data_type_o !== dt_before || word_count_o !== wc_before) begin
            failures++;
            $display("FAIL ecc_bad_latch got vc=%h dt=%h wc=%h expected vc=%h dt=%h wc=%h",
                     vc_o, data_type_o, word_count_o, vc_before, dt_before, wc_before);
        end
        idle(2);
        step(1'b1, hdr(2'd2, 6'h00, 16'h00A5));
        step(1'b0, 32'd0);
        checks++;
        if (frame_start_o !== 1'b1 || pkt_error_o !== 1'b0 || word_count_o !== 16'h00A5) begin
            failures++;
            $display("FAIL ecc_good got fs=%b err=%b wc=%h expected fs=1 err=0 wc=00a5",
                     frame_start_o, pkt_error_o, word_count_o);
        end
        idle(2);
        @(negedge clk_i); #1;
        checks++;
        if (n_fs - fs0 != 1 || n_err - e0 != 1) begin
            failures++;
            $display("FAIL ecc_summary got fs=%0d err=%0d expected 1 1", n_fs - fs0, n_err - e0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_short_fs();
        test_long_payload();
        test_drop();
        test_wc_over();
        test_back_to_back();
        test_reset_mid();
`ifdef MIPI_RX_PACKET_ECC_CHECK_EN
        test_ecc();
`endif
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mipi_rx_packet_ctrl.md
MIPI_RX_PACKET_CTRL -- requirements
Module: mipi_rx_packet_ctrl

Interface
REQ-001 SHALL have parameter: WC_LIMIT, 16'd8192, largest accepted long-packet word count in bytes.
REQ-002 SHALL have port: clk_i  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: lane_valid_i  in  1  aligned 4-lane word valid (from lane aligner).
REQ-005 SHALL have port: lane_byte_i  in  32  aligned word; [7:0] earliest byte.
REQ-006 SHALL have ports: frame_start_o, frame_end_o, line_start_o, line_end_o  out  1 each  one-cycle short-packet strobes.
REQ-007 SHALL have ports: vc_o  out  2, data_type_o  out  6, word_count_o  out  16  latched header fields.
REQ-008 SHALL have ports: payload_valid_o  out  1, payload_o  out  32, payload_be_o  out  4, payload_last_o  out  1.
REQ-009 SHALL have ports: pkt_error_o  out  1  one-cycle error strobe; busy_o  out  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, PAYLOAD, WAIT_END.
REQ-011 SHALL treat the first lane_valid_i=1 cycle in IDLE as header: byte0 = {VC[7:6], DT[5:0]}, byte1 = WC LSB, byte2 = WC MSB, byte3 = ECC.
REQ-012 SHALL register vc_o, data_type_o and word_count_o one cycle after the header cycle; they hold until the next header.
REQ-013 SHALL classify DT 0x00-0x0F as short packets; DT 0x00/0x01/0x02/0x03 pulse frame_start_o/frame_end_o/line_start_o/line_end_o one cycle after header; other short DTs pulse nothing.
REQ-014 SHALL on short packet go to WAIT_END if lane_valid_i is still high in the following cycle, else IDLE.
REQ-015 SHALL on long packet with 0 < WC <= WC_LIMIT load remaining counter with WC and enter PAYLOAD; with WC=0 enter WAIT_END with no payload.
REQ-016 SHALL on long packet with WC > WC_LIMIT pulse pkt_error_o and enter WAIT_END without payload.
REQ-017 SHALL in PAYLOAD, per lane_valid_i=1 cycle, register payload_o = lane_byte_i with payload_valid_o=1 one cycle later (latency 1) and decrement remaining by 4 (saturating at 0).
REQ-018 SHALL set payload_be_o = 4'b1111 when remaining >= 4, else 4'b0001/0011/0111 for remaining 1/2/3.
REQ-019 SHALL assert payload_last_o with the word where remaining <= 4, then enter WAIT_END (CRC and trailer discarded).
REQ-020 SHALL, if lane_valid_i drops in PAYLOAD before last word, pulse pkt_error_o, not assert payload_last_o, return to IDLE.
REQ-021 SHALL in WAIT_END ignore data and return to IDLE on first lane_valid_i=0 cycle; a new header requires at least one lane_valid_i=0 cycle.
REQ-022 SHALL keep payload_valid_o, payload_last_o, strobes and pkt_error_o low outside their defined cycles; payload_o/payload_be_o are 0 when payload_valid_o=0.

Reset
REQ-023 SHALL on reset_i, asynchronously: state IDLE, remaining 0, every output 0.
REQ-024 SHALL, if reset_i asserts mid-packet, produce no payload_last_o or pkt_error_o for the aborted packet; after release, wait in IDLE; a still-high lane_valid_i is taken as header only after it is seen low once.

Configuration
REQ-025 SHALL, with MIPI_RX_PACKET_ECC_CHECK_EN defined, compute the CSI-2 6-bit header ECC over bytes0-2 and compare with byte3[5:0]; on mismatch pulse pkt_error_o, suppress strobes/payload, latch nothing, enter WAIT_END.
REQ-026 SHALL, without MIPI_RX_PACKET_ECC_CHECK_EN, ignore byte3 entirely; no ECC logic synthesised.

Structure
REQ-027 SHALL place DT constants (FS 0x00, FE 0x01, LS 0x02, LE 0x03, short-packet bound 0x0F) and state encoding in shared package mipi_rx_pkg.
REQ-028 SHALL implement ECC as combinational sub-module mipi_rx_ecc (24-bit in, 6-bit out), instantiated only under MIPI_RX_PACKET_ECC_CHECK_EN.

Verification
REQ-029 SHALL cover: header 0x00_0000_00 (FS, ECC valid) one valid cycle -> frame_start_o pulse 1 cycle later, busy_o back to 0.
REQ-030 SHALL cover: long header DT 0x2A WC=10, then words 0x44332211, 0x88776655, 0xXXXXAA99, CRC -> 3 payload beats, be 1111/1111/0011, payload_last_o on 3rd, word_count_o=10.
REQ-031 SHALL cover: WC=8 with lane_valid_i dropped after first payload word -> one beat, pkt_error_o pulse, no payload_last_o, state IDLE.
REQ-032 SHALL cover: WC=16'd9000 (> WC_LIMIT) -> pkt_error_o pulse, no payload_valid_o, IDLE after lane_valid_i low.
REQ-033 SHALL cover: reset_i pulsed during PAYLOAD with lane_valid_i held high -> all outputs 0 immediately, no header accepted until lane_valid_i low then high.
REQ-034 SHALL cover (ECC build): FS header with byte3 corrupted -> pkt_error_o, no frame_start_o; correct ECC -> frame_start_o.
